demux4_route_fifo: RTL
======================

Name: demux4_route_fifo

Overview:
- Inverse of the team's N:1 datapath muxes: a 1:4 routing demultiplexer with a valid/ready handshake.
- Accepts one WIDTH-bit word per cycle on a single input port, tagged with a 2-bit channel select.
- Pushes the word into a small per-channel FIFO; each channel drains independently through its own valid/ready output.
- Sits between a shared producer (fetch/decode/result bus) and four independent consumers.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 2, entries per channel FIFO; power of two, at least 2.
- CNT_W, 16, width of each optional per-channel transfer counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  producer has a word.
- in_ready  out  1  block accepts the word this cycle.
- in_data  in  WIDTH  word to route.
- in_sel  in  2  destination channel, 0..3.
- out_valid  out  4  bit k: channel k head entry valid.
- out_ready  in  4  bit k: consumer k takes the head.
- out_data  out  4*WIDTH  channel k head at [WIDTH*k+WIDTH-1 : WIDTH*k].
- xfer_cnt  out  4*CNT_W  present only with DEMUX_STATS_EN; channel k at [CNT_W*k+CNT_W-1 : CNT_W*k].

Behaviour:
- Push to channel k happens when in_valid & in_ready & in_sel==k. Pop of channel k happens when out_valid[k] & out_ready[k].
- in_ready = (count[in_sel] != DEPTH).
  - Depends only on registered count and in_sel; never on out_ready, so there is no ready-to-ready combinational path.
  - A full channel stays not-ready even while popping in the same cycle.
- Latency: a word accepted at edge N is visible on out_valid/out_data of its channel after edge N. There is no same-cycle bypass.
- Per-channel FIFO state:
  - read pointer, write pointer (log2 DEPTH bits, wrap modulo DEPTH) and count (0..DEPTH).
  - out_valid[k] = (count[k] != 0); out_data for channel k = mem[k][rptr[k]].
- Simultaneous push and pop on the same channel: both pointers advance and count is unchanged. Legal when count is 1..DEPTH-1. At count 0 only the push occurs; at DEPTH only the pop occurs.
- Channels are fully independent: ordering is preserved within a channel; there is no ordering relation across channels.
- A consumer may hold out_ready high with out_valid low; nothing happens.
- out_data of an empty channel is don't-care for checking, but holds the last-written slot (memory is not cleared).
- Input stability: in_data/in_sel may change freely while in_ready=0; the block does not latch them.
- Reset (asynchronous, any time, including mid-transfer):
  - all counts and pointers go to 0, so out_valid=0 and in_ready=1 once rst deasserts.
  - storage contents are not reset; in-flight words are discarded.
- Data bits are moved unmodified; no arithmetic on the datapath.

Optional Feature:
- DEMUX_STATS_EN defined:
  - adds the xfer_cnt port, with one CNT_W-bit counter per channel.
  - a counter increments on each pop of its channel and wraps from all-ones to 0.
  - reset value is 0.
- Undefined: no port, no counters, and behaviour otherwise identical.

Decomposition:
- Shared package/header holds:
  - NUM_CH=4 and SEL_W=2;
  - default WIDTH/DEPTH/CNT_W;
  - channel-slice index helper constants for out_data/xfer_cnt packing.
- One sub-module: demux_chan_fifo (DEPTH-entry FIFO with push, pop, full, empty, head and optional counter), instantiated 4 times from a generate loop.
- The top level holds only the select decode (push_k = in_valid & in_ready & in_sel==k) and the in_ready mux over the four full flags.

Test Plan:
- Reset then in_valid=1, in_sel=2, in_data=0xDEADBEEF -> in_ready=1; after one edge, out_valid=4'b0100 and channel 2 data=0xDEADBEEF; other channels are not valid.
- Fill channel 1 with 0x11, 0x22, holding out_ready=0 -> third push with sel=1 sees in_ready=0. Same cycle with sel=3 sees in_ready=1. Drain channel 1 -> data 0x11 then 0x22 in order.
- Channel 0 at count 1 (0xA0), push 0xA1 while out_ready[0]=1 -> count stays 1, head becomes 0xA1.
- Channel full (count=2), out_ready=1 and in_valid with the same sel -> in_ready=0; only the pop occurs and count becomes 1.
- Assert rst mid-stream with channels at counts 2,1,0,2 -> immediately out_valid=0; after release, in_ready=1 for every sel.
- With DEMUX_STATS_EN, force channel 3's counter to 0xFFFF via 65535 pops, then pop once more -> xfer_cnt[3]=0x0000; other counters unchanged.

Source files
------------

// File: rtl/demux4_route_fifo_pkg.sv
// Shared constants for the 1:4 routing demux and its per-channel FIFOs.
// Optional transfer counters are enabled with DEMUX_STATS_EN.
package demux4_route_fifo_pkg;

    localparam int NUM_CH    = 4;
    localparam int SEL_W     = 2;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 2;
    localparam int DEF_CNT_W = 16;

    // Low bit of channel ch's slice in a packed NUM_CH*w bus.
    function automatic int ch_lo(input int ch, input int w);
        return ch * w;
    endfunction

endpackage

// File: rtl/demux4_route_fifo_chan.sv
// One DEPTH-entry channel FIFO with head output and optional pop counter.
// DEMUX_STATS_EN adds the xfer_cnt port and its counter.
module demux_chan_fifo
    import demux4_route_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
`ifdef DEMUX_STATS_EN
    ,
    parameter int CNT_W = DEF_CNT_W
`endif
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             ready,
    output logic             full,
    output logic             valid,
    output logic [WIDTH-1:0] head
`ifdef DEMUX_STATS_EN
    ,
    output logic [CNT_W-1:0] xfer_cnt
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_B = $clog2(DEPTH + 1);

    localparam logic [CNT_B-1:0] FULL_CNT = CNT_B'(DEPTH);
    localparam logic [CNT_B-1:0] CNT_ONE  = CNT_B'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rptr;
    logic [PTR_W-1:0] wptr;
    logic [CNT_B-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign valid   = (count != '0);
    assign head    = mem[rptr];
    assign do_push = push & ~full;
    assign do_pop  = valid & ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (do_push)
                wptr <= wptr + PTR_ONE;
            if (do_pop)
                rptr <= rptr + PTR_ONE;
            if (do_push && !do_pop)
                count <= count + CNT_ONE;
            else if (!do_push && do_pop)
                count <= count - CNT_ONE;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wptr] <= wdata;
    end

`ifdef DEMUX_STATS_EN
    localparam logic [CNT_W-1:0] XFER_ONE = CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            xfer_cnt <= '0;
        else if (do_pop)
            xfer_cnt <= xfer_cnt + XFER_ONE;
    end
`endif

endmodule

// File: rtl/demux4_route_fifo.sv
// 1:4 routing demux: one valid/ready input, four independently drained FIFOs.
// DEMUX_STATS_EN adds per-channel pop counters on xfer_cnt.
module demux4_route_fifo
    import demux4_route_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
`ifdef DEMUX_STATS_EN
    ,
    parameter int CNT_W = DEF_CNT_W
`endif
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_data,
    input  logic [SEL_W-1:0]        in_sel,
    output logic [NUM_CH-1:0]       out_valid,
    input  logic [NUM_CH-1:0]       out_ready,
    output logic [NUM_CH*WIDTH-1:0] out_data
`ifdef DEMUX_STATS_EN
    ,
    output logic [NUM_CH*CNT_W-1:0] xfer_cnt
`endif
);

    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] push;

    // Registered full flags only: no path from out_ready to in_ready.
    assign in_ready = ~full[in_sel];

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign push[k] = in_valid & in_ready
                       & (in_sel == SEL_W'(k));

        demux_chan_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
`ifdef DEMUX_STATS_EN
            ,
            .CNT_W (CNT_W)
`endif
        ) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .push     (push[k]),
            .wdata    (in_data),
            .ready    (out_ready[k]),
            .full     (full[k]),
            .valid    (out_valid[k]),
            .head     (out_data[ch_lo(k, WIDTH) +: WIDTH])
`ifdef DEMUX_STATS_EN
            ,
            .xfer_cnt (xfer_cnt[ch_lo(k, CNT_W) +: CNT_W])
`endif
        );
    end

endmodule
